// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair.
//   SPI_WIDTH   : frame length in bits, common to both ends of the link
//   spi_state_e : slave frame state encoding
//   IDLE_FILL   : word shifted out on miso when no response is pending
package spi_pkg;

    localparam int SPI_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } spi_state_e;

    localparam logic [SPI_WIDTH-1:0] IDLE_FILL = 16'h0000;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered edge detection.
//   clk, reset : system clock, async active-high reset
//   d_i        : asynchronous input
//   level_o    : synchronized level
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
// RESET_VAL is the level the chain (and edge register) assumes after reset,
// so an input already sitting at that level produces no spurious edge.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI target for fixed-length full-duplex frames.
// sclk/cs/mosi are oversampled into the clk domain.
//   clk, reset        : system clock, async active-high reset
//   sclk, cs, mosi    : SPI pins from the master (cs active-low)
//   miso, miso_oe     : serial response and its drive enable
//   tx_data, tx_load  : response word for the next frame, accepted when tx_ready
//   tx_ready          : no response word pending
//   rx_data, rx_valid : last complete received word, one-cycle update pulse
//   busy              : frame in progress
//   frame_err         : one-cycle pulse when a frame is cut short
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d_i(sclk),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // cs resets to "selected" so a cs held low through reset cannot start a
    // frame; the master must deselect and reselect first.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .d_i(cs),
        .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d_i(mosi),
        .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             pending_q, pending_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d;
    logic [WIDTH-1:0] start_word;

    assign start_word = pending_q ? tx_buf_q : WIDTH'(IDLE_FILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            rx_data_q   <= '0;
            pending_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            rx_data_q   <= rx_data_d;
            pending_q   <= pending_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        rx_data_d   = rx_data_q;
        pending_d   = pending_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;

        // Load and frame-start consumption are gated by the same old
        // pending_q, so a load coinciding with a frame start either is
        // refused (word already pending, consumed now) or becomes the
        // pending word for the following frame.
        if (tx_load && !pending_q) begin
            tx_buf_d  = tx_data;
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    tx_shift_d = start_word;
                    miso_d     = start_word[WIDTH-1];
                    miso_oe_d  = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    if (pending_q) pending_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    // A full count can only meet cs_rise here if the master
                    // deselects within a cycle of the last edge; keep the word.
                    if (bit_cnt_q == CNT_W'(WIDTH)) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (bit_cnt_q == CNT_W'(WIDTH)) begin
                    state_d    = ST_DONE;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    miso_d     = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end else if (sclk_fall) begin
                    tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    miso_d     = tx_shift_q[WIDTH-2];
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign tx_ready  = ~pending_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int H     = 6;   // sclk half period in clk cycles
    localparam int SETUP = 8;   // cs low to first sclk activity

    logic        clk = 1'b0;
    logic        reset, sclk, cs, mosi, miso, miso_oe;
    logic [15:0] tx_data, rx_data;
    logic        tx_load, tx_ready, rx_valid, busy, frame_err;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    // reference model state
    logic        m_pending;
    logic [15:0] m_buf;
    logic [15:0] m_rx;

    always @(posedge clk) begin
        if (rx_valid)  n_valid++;
        if (frame_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic load(input logic [15:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        if (!m_pending) begin
            m_buf     = w;
            m_pending = 1'b1;
        end
        @(negedge clk);
        chk("tx_ready_after_load", tx_ready, !m_pending);
    endtask

    // One master transaction of nbits sclk cycles; rst_at >= 0 pulses reset
    // just before that bit's rising edge.
    task automatic frame(input logic [15:0] word, input int nbits, input int rst_at);
        logic [15:0] exp_tx;
        logic [31:0] got_m, exp_m;
        int          v0, e0;
        bit          rst_done;
        v0       = n_valid;
        e0       = n_err;
        rst_done = 0;
        got_m    = '0;
        exp_m    = '0;
        exp_tx   = m_pending ? m_buf : 16'h0000;
        m_pending = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (SETUP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset     = 1'b0;
                rst_done  = 1;
                m_pending = 1'b0;
                m_rx      = 16'h0000;
            end
            mosi = (i < 16) ? word[15-i] : 1'($urandom);
            repeat (H) @(negedge clk);
            sclk  = 1'b1;
            got_m = {got_m[30:0], miso};
            exp_m = {exp_m[30:0], (i < 16 && !rst_done) ? exp_tx[15-i] : 1'b0};
            if (i == 0) begin
                chk("miso_oe_in_frame", miso_oe, !rst_done);
                chk("busy_in_frame", busy, !rst_done);
            end
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        if (nbits >= 16 && !rst_done) m_rx = word;
        chk("miso_bits", got_m, exp_m);
        chk("rx_valid_count", n_valid - v0, (nbits >= 16 && !rst_done) ? 1 : 0);
        chk("frame_err_count", n_err - e0, (nbits > 0 && nbits < 16 && !rst_done) ? 1 : 0);
        chk("rx_data", rx_data, m_rx);
        chk("miso_oe_idle", miso_oe, 0);
        chk("miso_idle", miso, 0);
        chk("busy_idle", busy, 0);
        chk("tx_ready", tx_ready, !m_pending);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r, nb;
        reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_load = 1'b0; tx_data = 16'h0000;
        m_pending = 1'b0; m_buf = 16'h0000; m_rx = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        load(16'hA55A);
        frame(16'h1234, 16, -1);
        frame(16'hFFFF, 16, -1);
        frame(16'h5A00, 7, -1);
        load(16'hC3C3);
        frame(16'hBEEF, 18, -1);
        load(16'h7777);
        frame(16'h9999, 16, 8);
        frame(16'h0F0F, 16, -1);

        fork
            frame(16'h3C3C, 16, -1);
            begin
                repeat (60) @(negedge clk);
                load(16'h1111);
                load(16'h2222);
            end
        join
        frame(16'h5A5A, 16, -1);
        frame(16'h0000, 0, -1);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(1, 0) == 1) load(16'($urandom));
            r = $urandom_range(9, 0);
            if (r < 6)       nb = 16;
            else if (r == 6) nb = $urandom_range(15, 1);
            else if (r == 7) nb = 0;
            else             nb = $urandom_range(18, 17);
            frame(16'($urandom), nb, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
